// File: rtl/avalon_pwm_pkg.sv
// Shared definitions for the Avalon-MM PWM register block: register map,
// CTRL/STATUS bit positions and the staged register set.
package avalon_pwm_pkg;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_DVSR        = 3'd1;
    localparam logic [2:0] ADDR_DUTY        = 3'd2;
    localparam logic [2:0] ADDR_STATUS      = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE_DUTY = 3'd4;

    localparam int unsigned CTRL_ENABLE_BIT      = 0;
    localparam int unsigned CTRL_APPLY_NOW_BIT   = 1;
    localparam int unsigned STATUS_PENDING_BIT   = 0;
    localparam int unsigned STATUS_FADE_BUSY_BIT = 1;

    // Staged values waiting for the next applying event; duty is stored
    // already clamped to full scale, so the upper bits read back as zero.
    typedef struct packed {
        logic [31:0] dvsr;
        logic [31:0] duty;
    } staged_regs_t;

endpackage

// File: rtl/avalon_pwm_fade.sv
// Single-step duty ramp: moves the active duty one LSB toward the target.
// Only instantiated when AVALON_PWM_FADE_EN is defined.
module avalon_pwm_fade #(
    parameter int unsigned R = 10
) (
    input  logic [R:0] duty,
    input  logic [R:0] target,
    output logic [R:0] next_duty,
    output logic       busy
);

    always_comb begin
        next_duty = duty;
        busy      = (duty != target);
        if (duty < target) begin
            next_duty = duty + (R+1)'(1);
        end else if (duty > target) begin
            next_duty = duty - (R+1)'(1);
        end
    end

endmodule

// File: rtl/avalon_pwm_regs.sv
// Avalon-MM register front end for a PWM core: staged DVSR/DUTY applied at
// period boundaries or on apply_now. Optional ramping under AVALON_PWM_FADE_EN.
module avalon_pwm_regs
    import avalon_pwm_pkg::*;
#(
    parameter int unsigned R = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_avs_chipselect,
    input  logic [2:0]   i_avs_address,
    input  logic         i_avs_write,
    input  logic         i_avs_read,
    input  logic [31:0]  i_avs_writedata,
    output logic [31:0]  o_avs_readdata,
    input  logic         i_period_start,
    output logic [R:0]   o_duty,
    output logic [31:0]  o_dvsr,
    output logic         o_enable
);

    localparam logic [31:0] DUTY_FULL = 32'(2**R);

    staged_regs_t staged;
    logic         access_ok;
    logic         pending;
    logic         enable;
    logic [R:0]   duty;
    logic [31:0]  dvsr;
    logic [31:0]  readdata;

    logic         wr_en;
    logic         rd_en;
    logic         rdwr_both;
    logic         stage_wr;
    logic         apply_now;
    logic         apply;
    logic         apply_done;
    logic         fade_busy;
    logic [R:0]   target;
    logic [R:0]   next_duty;
    logic [31:0]  clamped_duty;
    logic [31:0]  rd_mux;

    // Bus accesses are blocked until one full clock after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            access_ok <= 1'b0;
        end else begin
            access_ok <= 1'b1;
        end
    end

    assign wr_en     = access_ok & i_avs_chipselect & i_avs_write;
    assign rd_en     = access_ok & i_avs_chipselect & i_avs_read & ~i_avs_write;
    assign rdwr_both = access_ok & i_avs_chipselect & i_avs_read & i_avs_write;
    assign stage_wr  = wr_en && ((i_avs_address == ADDR_DVSR) || (i_avs_address == ADDR_DUTY));
    assign apply_now = wr_en && (i_avs_address == ADDR_CTRL) && i_avs_writedata[CTRL_APPLY_NOW_BIT];
    assign apply     = apply_now | (i_period_start & pending);
    assign target    = staged.duty[R:0];

    assign clamped_duty = (i_avs_writedata > DUTY_FULL) ? DUTY_FULL : i_avs_writedata;

`ifdef AVALON_PWM_FADE_EN
    avalon_pwm_fade #(.R(R)) u_fade (
        .duty      (duty),
        .target    (target),
        .next_duty (next_duty),
        .busy      (fade_busy)
    );
    assign apply_done = (next_duty == target);
`else
    assign next_duty  = target;
    assign fade_busy  = 1'b0;
    assign apply_done = 1'b1;
`endif

    always_comb begin
        rd_mux = '0;
        case (i_avs_address)
            ADDR_CTRL:        rd_mux[CTRL_ENABLE_BIT] = enable;
            ADDR_DVSR:        rd_mux = staged.dvsr;
            ADDR_DUTY:        rd_mux = staged.duty;
            ADDR_STATUS: begin
                rd_mux[STATUS_PENDING_BIT]   = pending;
                rd_mux[STATUS_FADE_BUSY_BIT] = fade_busy;
            end
            ADDR_ACTIVE_DUTY: rd_mux = 32'(duty);
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            staged   <= '0;
            pending  <= 1'b0;
            enable   <= 1'b0;
            duty     <= '0;
            dvsr     <= '0;
            readdata <= '0;
        end else begin
            if (wr_en) begin
                case (i_avs_address)
                    ADDR_CTRL: enable      <= i_avs_writedata[CTRL_ENABLE_BIT];
                    ADDR_DVSR: staged.dvsr <= i_avs_writedata;
                    ADDR_DUTY: staged.duty <= clamped_duty;
                    default:   ;
                endcase
            end

            // A coincident period start moves the previously staged values;
            // the new write keeps pending set for the following period.
            if (apply) begin
                dvsr <= staged.dvsr;
                duty <= next_duty;
            end

            if (stage_wr) begin
                pending <= 1'b1;
            end else if (apply && apply_done) begin
                pending <= 1'b0;
            end

            if (rd_en) begin
                readdata <= rd_mux;
            end else if (rdwr_both) begin
                readdata <= '0;
            end
        end
    end

    assign o_avs_readdata = readdata;
    assign o_duty         = duty;
    assign o_dvsr         = dvsr;
    assign o_enable       = enable;

endmodule

// File: doc/avalon_pwm_regs.md
AVALON_PWM_REGS -- requirements
Module: avalon_pwm_regs

Interface
REQ-001 Parameter R, default 10: duty resolution; o_duty is R+1 bits, and 2**R means 100 %.
REQ-002 i_clk  input  1  single clock; all logic is on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_avs_chipselect  input  1  Avalon-MM slave select.
REQ-005 i_avs_address  input  3  word address.
REQ-006 i_avs_write / i_avs_read  input  1 each  Avalon-MM write and read strobes.
REQ-007 i_avs_writedata  input  32  write data.
REQ-008 o_avs_readdata  output  32  read data, valid 1 cycle after the read strobe.
REQ-009 i_period_start  input  1  one-cycle pulse marking the start of a PWM period, from the downstream core's integration.
REQ-010 o_duty  output  R+1  active duty, driven to the pwm core i_duty input.
REQ-011 o_dvsr  output  32  active prescale divisor, driven to the pwm core i_dvsr input.
REQ-012 o_enable  output  1  PWM enable; the integration gates o_pwm with it.

Function
REQ-013 Register map:
- 0 CTRL: bit0 enable (RW); bit1 apply_now (write-1, self-clearing, reads 0).
- 1 DVSR: staged divisor (RW).
- 2 DUTY: staged target duty (RW, R+1 bits).
- 3 STATUS: bit0 pending, bit1 fade_busy (RO).
- 4 ACTIVE_DUTY: current o_duty (RO).
REQ-014 Unmapped reads SHALL return 0; unmapped writes and writes to RO registers SHALL be ignored.
REQ-015 A transaction SHALL occur only when chipselect is high; read and write asserted together SHALL perform the write only, and the read data returns 0.
REQ-016 Read data SHALL be registered with fixed 1-cycle latency and no waitrequest; o_avs_readdata holds its value between reads.
REQ-017 A DUTY write greater than 2**R SHALL be clamped to 2**R when stored.
REQ-018 A write to DVSR or DUTY SHALL set pending.
REQ-019 o_dvsr and o_duty SHALL change only on the cycle after i_period_start while pending is set, or on the cycle after an apply_now write; the transfer clears pending.
REQ-020 A DVSR/DUTY write in the same cycle as i_period_start SHALL be staged and applied at the next period start, with pending left set.
REQ-021 o_enable SHALL follow CTRL.enable immediately, 1 cycle after the write.
REQ-022 While o_enable is 0, i_period_start SHALL still apply staged values.

Reset
REQ-023 While i_rst_n is low, all registers SHALL clear asynchronously: o_duty=0, o_dvsr=0, o_enable=0, o_avs_readdata=0, pending=0, fade_busy=0.
REQ-024 Reset release SHALL be synchronous to the design's use of i_clk; no Avalon access is honoured on the release cycle.
REQ-025 A reset asserted in the middle of a fade SHALL abandon the fade, with no residual state.

Configuration
REQ-026 Macro AVALON_PWM_FADE_EN.
- Defined: on each applying event, o_duty SHALL step by exactly 1 toward the staged target, and fade_busy SHALL be high while o_duty differs from the target.
- Defined: pending SHALL clear only when o_duty equals the target.
- Defined: a new DUTY write during a fade SHALL retarget from the current o_duty.
REQ-027 Without AVALON_PWM_FADE_EN, o_duty SHALL load the target in one step, fade_busy SHALL read 0, and the fade logic is absent.

Structure
REQ-028 Shared package avalon_pwm_pkg SHALL hold:
- register address localparams (CTRL, DVSR, DUTY, STATUS, ACTIVE_DUTY);
- CTRL and STATUS bit-index localparams;
- a packed struct typedef for the staged register set.
REQ-029 Sub-module avalon_pwm_fade (step/compare logic) is natural and SHALL be instantiated only under AVALON_PWM_FADE_EN; Avalon decode stays in avalon_pwm_regs.

Verification
REQ-030 Write DVSR=99, DUTY=512, then pulse i_period_start -> o_dvsr=99 and o_duty=512 one cycle later; STATUS.pending 1 before the pulse, 0 after.
REQ-031 Write DUTY=2000 with R=10 -> a DUTY read returns 1024; after apply_now, o_duty=1024.
REQ-032 Write DUTY=300 in the same cycle as i_period_start -> o_duty is unchanged; the next pulse gives o_duty=300.
REQ-033 AVALON_PWM_FADE_EN with o_duty=10: write DUTY=13, then 3 pulses -> o_duty 11, 12, 13; fade_busy falls with the 3rd step.
REQ-034 Assert i_rst_n=0 mid-fade, asynchronous to i_clk -> all outputs 0 immediately; after release, a STATUS read returns 0.
REQ-035 Read address 6 -> 0 returned 1 cycle later; read with write both high at address 1 -> write taken, readdata 0.
